// File: rtl/m2014_q6_fsm.sv
// m2014_q6_fsm: registered six-state sequencer driven by qualified samples of w.
//
// Optional feature macro: M2014_Q6_FSM_CNT_EN builds the saturating E-entry
// counter; when it is undefined, cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk       rising-edge clock
//   aresetn   asynchronous active-low reset (synchronous release)
//   w_valid   qualifies w; the state advances only when high
//   w         serial decision input
//   ld_en     loads ld_state (priority over w_valid)
//   ld_state  state code to load; illegal codes force A and set err
//   err_clr   clears the sticky err flag (a same-edge set wins)
//   y         current state (registered)
//   z         Moore output, high in states E and F (registered)
//   err       sticky illegal-load flag
//   cnt       saturating count of w-driven entries into E
module m2014_q6_fsm #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             w_valid,
  input  logic             w,
  input  logic             ld_en,
  input  logic [2:0]       ld_state,
  input  logic             err_clr,
  output logic [2:0]       y,
  output logic             z,
  output logic             err,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [2:0] {
    ST_A = 3'b000,
    ST_B = 3'b001,
    ST_C = 3'b010,
    ST_D = 3'b011,
    ST_E = 3'b100,
    ST_F = 3'b101
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   z_nxt;
  logic   err_nxt;

  // State, z and err registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_A;
      z     <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= z_nxt;
      err   <= err_nxt;
    end
  end

  assign y = state;

  // Next-state, next-z and next-err decode.
  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    if (err_clr) begin
      err_nxt = 1'b0;
    end
    if (ld_en) begin
      // Illegal codes are redirected to A so the register never holds them.
      if (ld_state inside {3'b110, 3'b111}) begin
        state_nxt = ST_A;
        err_nxt   = 1'b1;
      end else begin
        state_nxt = state_t'(ld_state);
      end
    end else if (w_valid) begin
      case (state)
        ST_A:    state_nxt = w ? ST_A : ST_B;
        ST_B:    state_nxt = w ? ST_D : ST_C;
        ST_C:    state_nxt = w ? ST_D : ST_E;
        ST_D:    state_nxt = w ? ST_A : ST_F;
        ST_E:    state_nxt = w ? ST_D : ST_E;
        ST_F:    state_nxt = w ? ST_D : ST_C;
        default: state_nxt = ST_A;
      endcase
    end
    // z is registered from the next state so it lines up with the new y.
    z_nxt = (state_nxt == ST_E) || (state_nxt == ST_F);
  end

`ifdef M2014_Q6_FSM_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic e_entry;

  // Only w-driven arrivals from another state count; loads and E->E do not.
  assign e_entry = !ld_en && w_valid && (state != ST_E) && (state_nxt == ST_E);

  // Saturating E-entry counter.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (e_entry && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_m2014_q6_fsm.sv
// Self-checking bench for m2014_q6_fsm: directed steps plus a random tail,
// with expected outputs pushed to a scoreboard queue and popped after each edge.
module tb_m2014_q6_fsm;

  localparam int unsigned CNT_W = 2;
`ifdef M2014_Q6_FSM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             aresetn;
  logic             w_valid;
  logic             w;
  logic             ld_en;
  logic [2:0]       ld_state;
  logic             err_clr;
  logic [2:0]       y;
  logic             z;
  logic             err;
  logic [CNT_W-1:0] cnt;

  m2014_q6_fsm #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .w_valid  (w_valid),
    .w        (w),
    .ld_en    (ld_en),
    .ld_state (ld_state),
    .err_clr  (err_clr),
    .y        (y),
    .z        (z),
    .err      (err),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       y;
    logic             z;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [2:0]       m_y;
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Transition table written straight from the state diagram.
  function automatic logic [2:0] next_of(input logic [2:0] s, input logic wi);
    case (s)
      3'b000:  return wi ? 3'b000 : 3'b001;
      3'b001:  return wi ? 3'b011 : 3'b010;
      3'b010:  return wi ? 3'b011 : 3'b100;
      3'b011:  return wi ? 3'b000 : 3'b101;
      3'b100:  return wi ? 3'b011 : 3'b100;
      3'b101:  return wi ? 3'b011 : 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_y   = 3'b000;
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  task automatic do_step(input string tag, input logic vld, input logic wi,
                         input logic ld, input logic [2:0] lds, input logic clr);
    logic [2:0] ny;
    logic       eset;
    exp_t       e;
    exp_t       o;
    @(negedge clk);
    w_valid  = vld;
    w        = wi;
    ld_en    = ld;
    ld_state = lds;
    err_clr  = clr;
    eset = 1'b0;
    if (ld) begin
      if (lds == 3'b110 || lds == 3'b111) begin
        ny   = 3'b000;
        eset = 1'b1;
      end else begin
        ny = lds;
      end
    end else if (vld) begin
      ny = next_of(m_y, wi);
    end else begin
      ny = m_y;
    end
    if (CNT_EN && !ld && vld && m_y != 3'b100 && ny == 3'b100 && m_cnt != '1)
      m_cnt = m_cnt + CNT_W'(1);
    if (eset) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_y = ny;
    e.y = m_y;
    e.z = (m_y == 3'b100) || (m_y == 3'b101);
    e.err = m_err;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      checks--;
      o = sb.pop_front();
      chk({tag, "_y"}, 32'(y), 32'(o.y));
      chk({tag, "_z"}, 32'(z), 32'(o.z));
      chk({tag, "_err"}, 32'(err), 32'(o.err));
      chk({tag, "_cnt"}, 32'(cnt), 32'(o.cnt));
    end
  endtask

  task automatic wstep(input string tag, input logic wi);
    do_step(tag, 1'b1, wi, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic idle_inputs();
    w_valid  = 1'b0;
    w        = 1'b0;
    ld_en    = 1'b0;
    ld_state = 3'b000;
    err_clr  = 1'b0;
  endtask

  initial begin
    idle_inputs();
    aresetn = 1'b1;
    model_reset();
    #1 aresetn = 1'b0;
    #2;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) aresetn = 1'b1;

    // Stays in A until a qualifying w=0.
    do_step("hold0", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    do_step("hold1", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    wstep("a_w1", 1'b1);
    chk("a_stays", 32'(y), 32'd0);

    // A -> B -> C -> E, then E self-loop.
    wstep("abc0", 1'b0);
    wstep("abc1", 1'b0);
    wstep("abc2", 1'b0);
    chk("enter_e_y", 32'(y), 32'h4);
    chk("enter_e_z", 32'(z), 32'd1);
    chk("enter_e_cnt", 32'(cnt), CNT_EN ? 32'd1 : 32'd0);
    wstep("e_loop", 1'b0);
    chk("e_loop_cnt", 32'(cnt), CNT_EN ? 32'd1 : 32'd0);

    // E -> D -> A, then the walk 0,1,0,0,1,1.
    wstep("e_to_d", 1'b1);
    wstep("d_to_a", 1'b1);
    wstep("walk0", 1'b0);
    wstep("walk1", 1'b1);
    wstep("walk2", 1'b0);
    chk("walk_f_y", 32'(y), 32'h5);
    chk("walk_f_z", 32'(z), 32'd1);
    wstep("walk3", 1'b0);
    chk("walk_c_z", 32'(z), 32'd0);
    wstep("walk4", 1'b1);
    wstep("walk5", 1'b1);
    chk("walk_end_y", 32'(y), 32'd0);

    // Remaining edges: C w1 -> D, F w1 -> D.
    wstep("c_d0", 1'b0);
    wstep("c_d1", 1'b0);
    wstep("c_d2", 1'b1);
    wstep("f_d0", 1'b0);
    wstep("f_d1", 1'b1);
    chk("f_to_d_y", 32'(y), 32'h3);

    // w_valid low with w toggling: nothing moves.
    for (int i = 0; i < 10; i++) begin
      do_step("vld_low", 1'b0, 1'(i % 2), 1'b0, 3'b000, 1'b0);
    end
    chk("vld_low_y", 32'(y), 32'h3);

    // Legal loads; a load into E does not count.
    do_step("ld_f", 1'b1, 1'b1, 1'b1, 3'b101, 1'b0);
    do_step("ld_e", 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
    chk("ld_e_y", 32'(y), 32'h4);

    // Illegal load beats w; set beats clear; clear alone clears.
    do_step("ld_110", 1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
    chk("ld_110_y", 32'(y), 32'd0);
    chk("ld_110_err", 32'(err), 32'd1);
    do_step("ld_111_clr", 1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    chk("set_wins_err", 32'(err), 32'd1);
    do_step("clr", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    chk("clr_err", 32'(err), 32'd0);

    // Five C->E entries to saturate the counter.
    for (int k = 0; k < 5; k++) begin
      wstep("sat_a", 1'b0);
      wstep("sat_b", 1'b0);
      wstep("sat_c", 1'b0);
      wstep("sat_e", 1'b1);
      wstep("sat_d", 1'b1);
    end
    chk("sat_cnt", 32'(cnt), CNT_EN ? 32'd3 : 32'd0);

    // Asynchronous reset in the middle of activity.
    do_step("pre_rst_ld", 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    wstep("pre_rst0", 1'b0);
    wstep("pre_rst1", 1'b0);
    @(negedge clk);
    idle_inputs();
    aresetn = 1'b0;
    #2;
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_z", 32'(z), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    model_reset();
    sb.delete();
    @(negedge clk) aresetn = 1'b1;
    do_step("post_rst", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Random tail against the model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      do_step("rnd", (r[1:0] != 2'b00), r[2], (r[5:3] == 3'b000), r[8:6], (r[11:9] == 3'b000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
